// File: rtl/instr_mem_loader.sv
// Serial program loader: 16-bit word-count header followed by big-endian 32-bit words,
// one instruction-memory write per assembled word; the CPU is held in reset while loading.
module instr_mem_loader #(
    parameter int ROM_SIZE = 128,
    parameter int ROM_BIT  = 7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        cpu_hold
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_HDR_HI = 3'd1;
    localparam logic [2:0] S_HDR_LO = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;
    localparam logic [2:0] S_ERR    = 3'd5;

    logic [2:0]         state;
    logic [7:0]         count_hi;
    logic [15:0]        count;
    logic [ROM_BIT-1:0] index;
    logic [1:0]         byte_cnt;
    logic [23:0]        shift;

    logic        accept;
    logic [15:0] hdr_count;
    logic        last_word;

    assign accept    = rx_valid && rx_ready;
    assign hdr_count = {count_hi, rx_data};
    assign last_word = (16'(index) + 16'd1) == count;

    // Handshake and status are pure state decodes, so rx_ready never looks at rx_valid.
    assign rx_ready = (state == S_HDR_HI) || (state == S_HDR_LO) || (state == S_DATA);
    assign busy     = rx_ready;
    assign cpu_hold = busy;
    assign done     = (state == S_DONE);
    assign error    = (state == S_ERR);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            count_hi <= '0;
            count    <= '0;
            index    <= '0;
            byte_cnt <= '0;
            shift    <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
        end else begin
            // NOTE: default-low here turns the single assignment below into a one-cycle pulse.
            wr_en <= 1'b0;
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        state    <= S_HDR_HI;
                        index    <= '0;
                        byte_cnt <= '0;
                    end
                end
                S_HDR_HI: begin
                    if (accept) begin
                        count_hi <= rx_data;
                        state    <= S_HDR_LO;
                    end
                end
                S_HDR_LO: begin
                    if (accept) begin
                        count <= hdr_count;
                        if (hdr_count == 16'd0)
                            state <= S_DONE;
                        else if (hdr_count > 16'(ROM_SIZE))
                            state <= S_ERR;
                        else
                            state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        shift    <= {shift[15:0], rx_data};
                        if (byte_cnt == 2'd3) begin
                            wr_en   <= 1'b1;
                            wr_addr <= 32'(index) << 2;
                            wr_data <= {shift, rx_data};
                            // Index stays put on the final word so it never passes ROM_SIZE-1.
                            if (last_word)
                                state <= S_DONE;
                            else
                                index <= index + ROM_BIT'(1);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader: header table, directed corner cases and
// randomized loads checked against a byte-stream reference model.
module tb_instr_mem_loader;

    localparam int ROM_SIZE = 128;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        busy;
    logic        done;
    logic        error;
    logic        cpu_hold;

    instr_mem_loader #(.ROM_SIZE(ROM_SIZE), .ROM_BIT(7)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .cpu_hold (cpu_hold)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    typedef struct {
        logic [7:0] hi;
        logic [7:0] lo;
        logic       exp_done;
        logic       exp_error;
        logic       exp_busy;
    } hdr_vec_t;

    int         checks   = 0;
    int         failures = 0;
    int         cyc      = 0;
    wr_t        wq[$];
    logic [7:0] stream[$];

    always @(posedge clk) cyc++;

    // Every write strobe is captured mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (wr_en === 1'b1) wq.push_back('{wr_addr, wr_data, cyc});
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        start    = 1'b0;
        rx_valid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic check_reset_outs(input string tag);
        check($sformatf("%s_rx_ready", tag), rx_ready, 0);
        check($sformatf("%s_wr_en", tag), wr_en, 0);
        check($sformatf("%s_wr_addr", tag), wr_addr, 0);
        check($sformatf("%s_wr_data", tag), wr_data, 0);
        check($sformatf("%s_busy", tag), busy, 0);
        check($sformatf("%s_done", tag), done, 0);
        check($sformatf("%s_error", tag), error, 0);
        check($sformatf("%s_cpu_hold", tag), cpu_hold, 0);
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_busy", busy, 1);
        check("start_rx_ready", rx_ready, 1);
        check("start_done_clr", done, 0);
        check("start_error_clr", error, 0);
    endtask

    // Offer one byte after `gap` idle cycles; returns just after the edge that takes it.
    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_valid = 1'b0;
        for (int g = 0; g < gap; g++) begin
            rx_data = 8'($urandom);
            tick();
        end
        rx_data  = b;
        rx_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (rx_ready) begin
                tick();
                rx_valid = 1'b0;
                return;
            end
            tick();
        end
        rx_valid = 1'b0;
        checks++;
        failures++;
        $display("FAIL send_timeout: byte 0x%02h not accepted within 50 cycles", b);
    endtask

    // Reference model: the header decides the outcome, word i goes to byte address 4*i
    // and is built from stream bytes 2+4i .. 5+4i, most significant first.
    task automatic run_and_check(input string tag, input int max_gap);
        logic [15:0] cnt;
        int          n_exp;
        logic [31:0] exp_data;
        wq.delete();
        do_start();
        foreach (stream[i]) send_byte(stream[i], (max_gap == 0) ? 0 : $urandom_range(max_gap, 0));
        cnt   = {stream[0], stream[1]};
        n_exp = (cnt == 16'd0 || cnt > 16'(ROM_SIZE)) ? 0 : int'(cnt);
        check($sformatf("%s_done", tag), done, (cnt <= 16'(ROM_SIZE)) ? 1 : 0);
        check($sformatf("%s_error", tag), error, (cnt > 16'(ROM_SIZE)) ? 1 : 0);
        check($sformatf("%s_busy", tag), busy, 0);
        check($sformatf("%s_cpu_hold", tag), cpu_hold, 0);
        check($sformatf("%s_rx_ready", tag), rx_ready, 0);
        check($sformatf("%s_last_wr_en", tag), wr_en, (n_exp > 0) ? 1 : 0);
        repeat (4) tick();
        check($sformatf("%s_num_writes", tag), wq.size(), n_exp);
        for (int i = 0; i < n_exp && i < wq.size(); i++) begin
            exp_data = {stream[2+4*i], stream[3+4*i], stream[4+4*i], stream[5+4*i]};
            check($sformatf("%s_addr%0d", tag, i), wq[i].addr, 32'(4 * i));
            check($sformatf("%s_data%0d", tag, i), wq[i].data, exp_data);
        end
    endtask

    task automatic build_stream(input int cnt);
        stream.delete();
        stream.push_back(8'(cnt >> 8));
        stream.push_back(8'(cnt));
        if (cnt >= 1 && cnt <= ROM_SIZE)
            for (int i = 0; i < 4 * cnt; i++) stream.push_back(8'($urandom));
    endtask

    hdr_vec_t vecs[6];

    initial begin
        int bad_spacing;
        int cnt;
        int r;

        reset    = 1'b1;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;

        // Reset state, and reset winning over a simultaneous start.
        do_reset();
        check_reset_outs("rst");
        reset = 1'b1;
        start = 1'b1;
        tick();
        reset = 1'b0;
        start = 1'b0;
        check_reset_outs("rst_vs_start");

        // Header outcome table.
        vecs[0] = '{8'h00, 8'h00, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{8'h00, 8'h81, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{8'h00, 8'h80, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{8'h01, 8'h00, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{8'h00, 8'h01, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{8'hFF, 8'hFF, 1'b0, 1'b1, 1'b0};
        for (int v = 0; v < 6; v++) begin
            do_start();
            send_byte(vecs[v].hi, 0);
            send_byte(vecs[v].lo, v % 3);
            check($sformatf("hdr%0d_done", v), done, vecs[v].exp_done);
            check($sformatf("hdr%0d_error", v), error, vecs[v].exp_error);
            check($sformatf("hdr%0d_busy", v), busy, vecs[v].exp_busy);
            check($sformatf("hdr%0d_rx_ready", v), rx_ready, vecs[v].exp_busy);
            check($sformatf("hdr%0d_cpu_hold", v), cpu_hold, vecs[v].exp_busy);
            check($sformatf("hdr%0d_wr_en", v), wr_en, 0);
            if (vecs[v].exp_busy) do_reset();
        end

        // Two-word load with known bytes.
        stream = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h14, 8'h01, 8'h00, 8'h00, 8'h08};
        run_and_check("two_words", 0);
        check("two_words_d0", wq.size() > 0 ? wq[0].data : 32'hx, 32'h20080014);
        check("two_words_d1", wq.size() > 1 ? wq[1].data : 32'hx, 32'h01000008);

        // Zero count: done immediately, CPU released.
        stream = '{8'h00, 8'h00};
        run_and_check("zero", 0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("zero_hold%0d", i), cpu_hold, 0);
            tick();
        end

        // Oversized count: error, and bytes offered in ERR are not consumed.
        stream = '{8'h00, 8'h81};
        run_and_check("over", 0);
        wq.delete();
        rx_data  = 8'hAA;
        rx_valid = 1'b1;
        repeat (3) tick();
        rx_valid = 1'b0;
        check("err_rx_ready", rx_ready, 0);
        check("err_sticky", error, 1);
        check("err_no_writes", wq.size(), 0);
        do_start();
        do_reset();

        // Three words with random stalls.
        build_stream(3);
        run_and_check("gaps3", 4);

        // Start during DATA is ignored and the partial word survives.
        wq.delete();
        do_start();
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("ign_start_busy", busy, 1);
        send_byte(8'h33, 0);
        send_byte(8'h44, 2);
        check("ign_start_done", done, 1);
        tick();
        check("ign_start_writes", wq.size(), 1);
        check("ign_start_data", wq.size() > 0 ? wq[0].data : 32'hx, 32'h11223344);
        check("ign_start_addr", wq.size() > 0 ? wq[0].addr : 32'hx, 32'h0);

        // Full memory at full rate: writes exactly 4 cycles apart.
        build_stream(ROM_SIZE);
        run_and_check("full", 0);
        bad_spacing = 0;
        for (int i = 1; i < wq.size(); i++)
            if (wq[i].cyc - wq[i-1].cyc != 4) bad_spacing++;
        check("full_spacing", bad_spacing, 0);
        check("full_last_addr", wq.size() > 0 ? wq[wq.size()-1].addr : 32'hx, 32'h1FC);

        // Reset in the middle of a word discards it.
        wq.delete();
        do_start();
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'hDE, 0);
        send_byte(8'hAD, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_reset_outs("mid_rst");
        repeat (3) tick();
        check("mid_rst_no_wr", wq.size(), 0);
        build_stream(1);
        run_and_check("after_rst", 1);

        // Randomized loads.
        for (int n = 0; n < 20; n++) begin
            r = $urandom_range(9, 0);
            if (r == 0)      cnt = 0;
            else if (r == 1) cnt = ROM_SIZE + 1 + $urandom_range(1000, 0);
            else             cnt = $urandom_range(6, 1);
            build_stream(cnt);
            run_and_check($sformatf("rnd%0d", n), 2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
